// File: rtl/lemon_pkg.sv
// Shared register-file constants and the write-back request payload type.
package lemon_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ZERO_IDX   = 0;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at an internal pointer,
// which moves to one past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    logic [PW-1:0]  r_ptr;
    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [N-1:0]   w_off;
    logic [2*N-1:0] w_off_dbl;
    logic [PW-1:0]  w_gidx;
    logic           w_found;
    int             w_gsum;

    // Rotate requests so bit 0 is the current highest-priority requester.
    assign w_req_dbl = {i_req, i_req} >> r_ptr;
    assign w_req_rot = w_req_dbl[N-1:0];

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        w_gsum  = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found  = 1'b1;
                w_off[k] = 1'b1;
                w_gsum   = int'(r_ptr) + k;
                if (w_gsum >= N) w_gsum = w_gsum - N;
                w_gidx   = PW'(w_gsum);
            end
        end
    end

    assign w_off_dbl = {w_off, w_off} << r_ptr;
    assign o_grant   = i_en ? w_off_dbl[2*N-1:N] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a one-entry registered write stage.
// Optional same-cycle read bypass of the committing write: RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import lemon_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_rd,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        wb_stall,
    input  logic [ADDR_WIDTH-1:0]       rs1,
    input  logic [ADDR_WIDTH-1:0]       rs2,
    input  logic [DATA_WIDTH-1:0]       rf_data1,
    input  logic [DATA_WIDTH-1:0]       rf_data2,
    output logic [DATA_WIDTH-1:0]       fwd_data1,
    output logic [DATA_WIDTH-1:0]       fwd_data2,
    output logic                        rf_wen,
    output logic [ADDR_WIDTH-1:0]       rf_rd,
    output logic [DATA_WIDTH-1:0]       rf_dataD,
    output logic                        busy
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_rd;
    logic [DATA_WIDTH-1:0] r_pend_data;

    logic                  w_drain;
    logic                  w_accept;
    logic                  w_hs;
    logic [N_REQ-1:0]      w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // An x0 entry still drains (frees the stage) but never asserts the write enable.
    assign w_drain  = r_pend_valid & ~wb_stall;
    assign w_accept = ~r_pend_valid | w_drain;
    assign rf_wen   = w_drain & (r_pend_rd != ZERO_IDX);
    assign rf_rd    = r_pend_rd;
    assign rf_dataD = r_pend_data;
    assign busy     = r_pend_valid;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req_valid),
        .i_en    (w_accept & ~rst),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_data  <= '0;
        end else if (w_accept) begin
            if (w_hs) begin
                r_pend_valid <= 1'b1;
                r_pend_rd    <= w_sel_rd;
                r_pend_data  <= w_sel_data;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign fwd_data1 = (rf_wen && (r_pend_rd == rs1) && (rs1 != ZERO_IDX)) ? r_pend_data : rf_data1;
    assign fwd_data2 = (rf_wen && (r_pend_rd == rs2) && (rs2 != ZERO_IDX)) ? r_pend_data : rf_data2;
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1, rs2};
    assign fwd_data1   = rf_data1;
    assign fwd_data2   = rf_data2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (N_REQ=2); expected writes go through a scoreboard queue.
module tb_rf_wb_arbiter;
    import lemon_pkg::*;

    localparam int N  = 2;
    localparam int AW = RF_ADDR_WIDTH;
    localparam int DW = RF_DATA_WIDTH;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_rd;
    logic [N*DW-1:0] req_data;
    logic            wb_stall;
    logic [AW-1:0]   rs1, rs2;
    logic [DW-1:0]   rf_data1, rf_data2, fwd_data1, fwd_data2;
    logic            rf_wen;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_dataD;
    logic            busy;

    logic [AW+DW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data), .wb_stall(wb_stall),
        .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] data);
        req_valid[i]           = v;
        req_rd[i*AW +: AW]     = rd;
        req_data[i*DW +: DW]   = data;
    endtask

    task automatic expect_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        exp_q.push_back({rd, data});
    endtask

    // scoreboard monitor: every register-file write must match the queue head
    always @(negedge clk) begin
        if (rf_wen) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: write rd=%0d data=%h, expected no write", rf_rd, rf_dataD);
            end else begin
                logic [AW+DW-1:0] w;
                w = exp_q.pop_front();
                check("wb_rd", 64'(rf_rd), 64'(w[AW+DW-1:DW]));
                check("wb_data", 64'(rf_dataD), 64'(w[DW-1:0]));
            end
        end
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_rd = '0; req_data = '0; wb_stall = 1'b0;
        rs1 = '0; rs2 = '0; rf_data1 = '0; rf_data2 = '0;
        #1 rst = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);

        // reset state with both requesters valid
        @(negedge clk);
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd", 64'(rf_rd), 64'd0);
        check("rst_dataD", 64'(rf_dataD), 64'd0);
        tick();
        rst = 1'b0;

        // fairness: grants alternate 0,1,0,1 starting with requester 0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fair_ready", 64'(req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
            if (k % 2 == 1) expect_write(5'd2, 32'h22);
            else            expect_write(5'd1, 32'h11);
            if (k > 0) check("fair_wen", 64'(rf_wen), 64'd1);
            tick();
        end
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("fair_last_wen", 64'(rf_wen), 64'd1);
        check("idle_ready", 64'(req_ready), 64'd0);
        tick();

        // single write from requester 0
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'd1);
        expect_write(5'd5, 32'hDEADBEEF);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("single_wen", 64'(rf_wen), 64'd1);
        check("single_busy", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        check("single_busy_clear", 64'(busy), 64'd0);
        check("single_wen_clear", 64'(rf_wen), 64'd0);
        tick();

        // stall: pending rd=7 held for 3 cycles, then write and new grant together
        set_req(1, 1'b1, 5'd7, 32'h77);
        @(negedge clk);
        check("stall_pre_ready", 64'(req_ready), 64'd2);
        expect_write(5'd7, 32'h77);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 5'd8, 32'h88);
        wb_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_wen", 64'(rf_wen), 64'd0);
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_rd_hold", 64'(rf_rd), 64'd7);
            check("stall_data_hold", 64'(rf_dataD), 64'h77);
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        check("unstall_wen", 64'(rf_wen), 64'd1);
        check("unstall_ready", 64'(req_ready), 64'd1);
        expect_write(5'd8, 32'h88);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("unstall_next_wen", 64'(rf_wen), 64'd1);
        tick();

        // bypass of the committing write to same-cycle readers
        rs1 = 5'd3; rf_data1 = 32'h0;
        rs2 = 5'd4; rf_data2 = 32'h5555;
        set_req(1, 1'b1, 5'd3, 32'hABCD);
        @(negedge clk);
        check("byp_ready", 64'(req_ready), 64'd2);
        expect_write(5'd3, 32'hABCD);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        wb_stall = 1'b1;
        @(negedge clk);
        check("byp_stall_wen", 64'(rf_wen), 64'd0);
        check("byp_stall_fwd1", 64'(fwd_data1), 64'd0);
        check("byp_stall_fwd2", 64'(fwd_data2), 64'h5555);
        tick();
        wb_stall = 1'b0;
        @(negedge clk);
        check("byp_fwd1", 64'(fwd_data1), BYP ? 64'hABCD : 64'd0);
        check("byp_fwd2_other_rs", 64'(fwd_data2), 64'h5555);
        tick();

        // x0 write: handshake consumes the slot but never writes
        set_req(0, 1'b1, 5'd0, 32'h1234);
        set_req(1, 1'b1, 5'd9, 32'h99);
        rs1 = 5'd0; rf_data1 = 32'hCAFE;
        @(negedge clk);
        check("x0_ready", 64'(req_ready), 64'd1);
        tick();
        @(negedge clk);
        check("x0_wen", 64'(rf_wen), 64'd0);
        check("x0_busy", 64'(busy), 64'd1);
        check("x0_next_ready", 64'(req_ready), 64'd2);
        check("x0_fwd1", 64'(fwd_data1), 64'hCAFE);
        expect_write(5'd9, 32'h99);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("x0_after_wen", 64'(rf_wen), 64'd1);
        tick();

        // reset mid-operation discards the pending write
        set_req(0, 1'b1, 5'd10, 32'hAA);
        @(negedge clk);
        check("mid_ready", 64'(req_ready), 64'd1);
        tick();
        rst = 1'b1;
        set_req(0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wen", 64'(rf_wen), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
